// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the 5-stage MIPS redirect pipeline.
//
// Captures the decoded ID fields and register-file operands on every rising
// clock edge. It loads a NOP bubble on a load-use stall or on a flush. It also
// registers the encoded forwarding selects for the EX-stage operand muxes, and
// runs a sticky consecutive-stall watchdog.
//
// Edge priority: flush > stall > load.
//
// Handshake: there is no valid/ready pair. ex_valid qualifies the ex_* payload.
// ifid_hold is the combinational back-pressure to PC and IF/ID: while it is
// high, the ID instruction is not consumed and is presented again next cycle.
//
// Optional feature: define ID_EX_PERF_CNT_EN to add the bubble_cnt and
// instr_cnt performance counters. Both are 32 bits and wrap.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   stall, flush          hazard-judge stall, branch/jump redirect
//   id_*                  decoded ID-stage instruction fields and operands
//   alu_{a,b}_{ex,mem}_eq operand source matches the EX / MEM destination
//   ifid_hold             stall & ~flush, freezes PC and IF/ID
//   ex_*                  registered EX-stage copy of the instruction
//   ex_fwd_a, ex_fwd_b    00 regfile, 01 EX/MEM result, 10 MEM/WB result
//   stall_timeout         sticky flag, set after MAX_STALL consecutive stalls
//   bubble_cnt, instr_cnt performance counters (ID_EX_PERF_CNT_EN only)
//   dbg_stall_run         current watchdog run length, for observation
module id_ex_stage_reg #(
  parameter int DATA_W    = 32,
  parameter int MAX_STALL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [5:0]        id_op,
  input  logic [5:0]        id_funct,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc,
  input  logic              alu_a_ex_eq,
  input  logic              alu_a_mem_eq,
  input  logic              alu_b_ex_eq,
  input  logic              alu_b_mem_eq,
  output logic              ifid_hold,
  output logic              ex_valid,
  output logic [5:0]        ex_op,
  output logic [5:0]        ex_funct,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic [1:0]        ex_fwd_a,
  output logic [1:0]        ex_fwd_b,
  output logic              stall_timeout,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       instr_cnt,
`endif
  output logic [3:0]        dbg_stall_run
);

  localparam logic [3:0] MAX_STALL_L = 4'(MAX_STALL);

  logic              valid_q, valid_d;
  logic [5:0]        op_q, op_d, funct_q, funct_d;
  logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d, pc_q, pc_d;
  logic [1:0]        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [3:0]        stall_run_q, stall_run_d;
  logic              timeout_q, timeout_d;
  logic              bubble;

  assign ifid_hold = stall & ~flush;
  assign bubble    = stall | flush;

  always_comb begin
    valid_d   = 1'b0;
    op_d      = '0;
    funct_d   = '0;
    rs_d      = '0;
    rt_d      = '0;
    rd_d      = '0;
    rs_data_d = '0;
    rt_data_d = '0;
    imm_d     = '0;
    pc_d      = '0;
    fwd_a_d   = 2'b00;
    fwd_b_d   = 2'b00;
    if (!bubble) begin
      valid_d   = id_valid;
      op_d      = id_op;
      funct_d   = id_funct;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rd_d      = id_rd;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm;
      pc_d      = id_pc;
      // The younger EX/MEM result wins when both destinations match.
      if (id_valid) begin
        fwd_a_d = alu_a_ex_eq ? 2'b01 : (alu_a_mem_eq ? 2'b10 : 2'b00);
        fwd_b_d = alu_b_ex_eq ? 2'b01 : (alu_b_mem_eq ? 2'b10 : 2'b00);
      end
    end
  end

  // A flush breaks a stall run because it also drops ifid_hold.
  always_comb begin
    stall_run_d = 4'd0;
    if (ifid_hold) begin
      stall_run_d = (stall_run_q == 4'hF) ? 4'hF : stall_run_q + 4'd1;
    end
    timeout_d = timeout_q | (stall_run_d >= MAX_STALL_L);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      op_q        <= '0;
      funct_q     <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      stall_run_q <= 4'd0;
      timeout_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      op_q        <= op_d;
      funct_q     <= funct_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_run_q <= stall_run_d;
      timeout_q   <= timeout_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_op         = op_q;
  assign ex_funct      = funct_q;
  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_rd         = rd_q;
  assign ex_rs_data    = rs_data_q;
  assign ex_rt_data    = rt_data_q;
  assign ex_imm        = imm_q;
  assign ex_pc         = pc_q;
  assign ex_fwd_a      = fwd_a_q;
  assign ex_fwd_b      = fwd_b_q;
  assign stall_timeout = timeout_q;
  assign dbg_stall_run = stall_run_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d, instr_cnt_q, instr_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q + (bubble ? 32'd1 : 32'd0);
    instr_cnt_d  = instr_cnt_q + ((!bubble && id_valid) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      instr_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign instr_cnt  = instr_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;
  localparam int DATA_W    = 32;
  localparam int MAX_STALL = 4;
  localparam int OW        = 1 + 6 + 6 + 15 + 4 * DATA_W + 4 + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [5:0] id_op = '0, id_funct = '0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic [DATA_W-1:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0, id_pc = '0;
  logic alu_a_ex_eq = 1'b0, alu_a_mem_eq = 1'b0, alu_b_ex_eq = 1'b0, alu_b_mem_eq = 1'b0;
  logic ifid_hold, ex_valid, stall_timeout;
  logic [5:0] ex_op, ex_funct;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc;
  logic [1:0] ex_fwd_a, ex_fwd_b;
  logic [3:0] dbg_stall_run;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt, instr_cnt;
  int m_bubbles = 0, m_instrs = 0;
`endif

  id_ex_stage_reg #(.DATA_W(DATA_W), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_op(id_op), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_pc(id_pc),
    .alu_a_ex_eq(alu_a_ex_eq), .alu_a_mem_eq(alu_a_mem_eq),
    .alu_b_ex_eq(alu_b_ex_eq), .alu_b_mem_eq(alu_b_mem_eq),
    .ifid_hold(ifid_hold), .ex_valid(ex_valid), .ex_op(ex_op), .ex_funct(ex_funct),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .stall_timeout(stall_timeout),
`ifdef ID_EX_PERF_CNT_EN
    .bubble_cnt(bubble_cnt), .instr_cnt(instr_cnt),
`endif
    .dbg_stall_run(dbg_stall_run)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [OW-1:0] exp_q[$];

  // reference model state
  int  m_run = 0;
  bit  m_timeout = 1'b0;

  wire [OW-1:0] act_vec = {ex_valid, ex_op, ex_funct, ex_rs, ex_rt, ex_rd,
                           ex_rs_data, ex_rt_data, ex_imm, ex_pc,
                           ex_fwd_a, ex_fwd_b, stall_timeout};

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_sel(input logic ex_eq, input logic mem_eq);
    if (ex_eq) return 2'd1;
    if (mem_eq) return 2'd2;
    return 2'd0;
  endfunction

  // monitor: pops one expected EX image after every active edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check_vec("ex_regs", act_vec, exp_q.pop_front());
  end

  task automatic set_random();
    id_valid     = 1'($urandom_range(0, 1));
    id_op        = 6'($urandom);
    id_funct     = 6'($urandom);
    id_rs        = 5'($urandom);
    id_rt        = 5'($urandom);
    id_rd        = 5'($urandom);
    id_rs_data   = $urandom;
    id_rt_data   = $urandom;
    id_imm       = $urandom;
    id_pc        = $urandom;
    alu_a_ex_eq  = 1'($urandom_range(0, 1));
    alu_a_mem_eq = 1'($urandom_range(0, 1));
    alu_b_ex_eq  = 1'($urandom_range(0, 1));
    alu_b_mem_eq = 1'($urandom_range(0, 1));
  endtask

  // driver: inputs are already applied (just after a negedge); check the
  // combinational hold, predict the next EX image, then advance one cycle.
  task automatic step();
    logic [OW-1:0] e;
    bit hold;
    #1;
    hold = stall && !flush;
    check_bit("ifid_hold", ifid_hold, hold);
    if (hold) m_run++; else m_run = 0;
    if (m_run >= MAX_STALL) m_timeout = 1'b1;
    if (stall || flush) begin
      e = '0;
      e[0] = m_timeout;
`ifdef ID_EX_PERF_CNT_EN
      m_bubbles++;
`endif
    end else begin
      e = {id_valid, id_op, id_funct, id_rs, id_rt, id_rd,
           id_rs_data, id_rt_data, id_imm, id_pc,
           id_valid ? fwd_sel(alu_a_ex_eq, alu_a_mem_eq) : 2'd0,
           id_valid ? fwd_sel(alu_b_ex_eq, alu_b_mem_eq) : 2'd0,
           m_timeout};
`ifdef ID_EX_PERF_CNT_EN
      if (id_valid) m_instrs++;
`endif
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic plain_step(input logic s, input logic f);
    set_random();
    stall = s;
    flush = f;
    step();
  endtask

  // asserts reset (possibly mid-stall), checks the cleared state, releases
  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    check_vec("reset_async", act_vec, '0);
    for (int i = 0; i < cycles; i++) begin
      set_random();
      stall = 1'($urandom_range(0, 1));
      flush = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check_vec("reset_hold", act_vec, '0);
    check_bit("reset_run", dbg_stall_run == 4'd0, 1'b1);
    rst_n = 1'b1;
    m_run = 0;
    m_timeout = 1'b0;
`ifdef ID_EX_PERF_CNT_EN
    m_bubbles = 0;
    m_instrs = 0;
`endif
  endtask

  initial begin
    @(negedge clk);
    do_reset(3);

    // first load after reset
    set_random(); stall = 0; flush = 0; id_valid = 1; id_op = 6'h23; step();

    // normal load with forwarding priority
    set_random(); stall = 0; flush = 0; id_valid = 1;
    id_op = 6'h00; id_funct = 6'h20; id_rs = 5'd3; id_rt = 5'd4; id_rd = 5'd5;
    id_rs_data = 32'h11; id_rt_data = 32'h22;
    alu_a_ex_eq = 1; alu_a_mem_eq = 1; alu_b_ex_eq = 0; alu_b_mem_eq = 1;
    step();

    // invalid instruction: forwarding selects forced to 00
    set_random(); stall = 0; flush = 0; id_valid = 0;
    alu_a_ex_eq = 1; alu_b_mem_eq = 1; step();

    // load-use stall then re-presented instruction
    set_random(); stall = 1; flush = 0; id_valid = 1; id_op = 6'h23; step();
    stall = 0; step();

    // flush together with stall
    set_random(); stall = 1; flush = 1; step();
    check_bit("flush_no_run", dbg_stall_run == 4'd0, 1'b1);

    // watchdog: 3 stalls no timeout, break, then 4 stalls timeout
    for (int i = 0; i < 3; i++) plain_step(1'b1, 1'b0);
    plain_step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) plain_step(1'b1, 1'b0);
    plain_step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) plain_step(1'b0, 1'b0);

    // long stall run to exercise saturation
    for (int i = 0; i < 18; i++) plain_step(1'b1, 1'b0);
    check_bit("run_saturated", dbg_stall_run == 4'hF, 1'b1);
    plain_step(1'b0, 1'b0);

    // reset mid-stall
    plain_step(1'b1, 1'b0);
    plain_step(1'b1, 1'b0);
    do_reset(1);

`ifdef ID_EX_PERF_CNT_EN
    for (int i = 0; i < 5; i++) begin
      set_random(); stall = 0; flush = 0; id_valid = 1; step();
    end
    plain_step(1'b1, 1'b0);
    plain_step(1'b1, 1'b0);
    plain_step(1'b0, 1'b1);
    check_bit("instr_cnt5", instr_cnt == 32'd5, 1'b1);
    check_bit("bubble_cnt3", bubble_cnt == 32'd3, 1'b1);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_random();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      step();
      if (i == 200) do_reset(2);
    end

`ifdef ID_EX_PERF_CNT_EN
    check_bit("instr_cnt", instr_cnt == 32'(m_instrs), 1'b1);
    check_bit("bubble_cnt", bubble_cnt == 32'(m_bubbles), 1'b1);
`endif

    stall = 0; flush = 0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
ID/EX pipeline register for the 5-stage MIPS redirect pipeline, directly downstream of the hazard/forwarding judge.
- Latches decoded ID fields and register-file operands each cycle.
- Consumes the judge's stall and forwarding-equality flags. Inserts a NOP bubble on load-use stall or flush.
- Registers encoded forwarding selects for the EX-stage ALU operand muxes.
- Tracks stall activity with a consecutive-stall watchdog.

Parameters:
DATA_W, 32, operand/immediate/PC width
MAX_STALL, 4, consecutive stall cycles before stall_timeout asserts (1..15)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  load-use stall from hazard judge
flush  in  1  branch/jump redirect; kill ID instruction
id_valid  in  1  ID stage holds a real instruction
id_op  in  6  opcode
id_funct  in  6  funct field
id_rs, id_rt, id_rd  in  5 each  register specifiers
id_rs_data, id_rt_data  in  DATA_W each  register-file read data
id_imm  in  DATA_W  extended immediate
id_pc  in  DATA_W  PC+4 of ID instruction
alu_a_ex_eq, alu_a_mem_eq  in  1 each  ALU-A source matches EX / MEM destination
alu_b_ex_eq, alu_b_mem_eq  in  1 each  ALU-B source matches EX / MEM destination
ifid_hold  out  1  freeze PC and IF/ID (combinational = stall & ~flush)
ex_valid  out  1  EX holds a real instruction
ex_op, ex_funct  out  6 each
ex_rs, ex_rt, ex_rd  out  5 each
ex_rs_data, ex_rt_data, ex_imm, ex_pc  out  DATA_W each
ex_fwd_a, ex_fwd_b  out  2 each  00 regfile, 01 EX/MEM result, 10 MEM/WB result
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (rst_n=0, async): every registered output is 0, including ex_valid, ex_fwd_a/b, stall_timeout, and internal counter. Release is synchronous to the next rising edge.
- Per-edge priority: flush > stall > load.
- Flush: bubble loaded. ex_valid=0; op, funct, rs, rt, rd = 0; fwd = 00; data, imm, pc = 0. Flush overrides a simultaneous stall.
- Stall without flush: identical bubble loaded; ID contents are not captured. ifid_hold=1 in the same cycle, so the instruction is re-presented next cycle.
- Load: all ex_* <= id_*; ex_valid <= id_valid.
  - ex_fwd_a = 01 if alu_a_ex_eq; else 10 if alu_a_mem_eq; else 00. EX priority when both flags are set.
  - ex_fwd_b: same rule using the alu_b flags.
  - If id_valid=0, forwarding selects load 00.
- Latency: 1 cycle ID->EX. No combinational path from id_* to ex_*.
- Watchdog: 4-bit saturating counter stall_run.
  - Increments on each edge with stall & ~flush; clears on any edge without it.
  - When stall_run reaches MAX_STALL, stall_timeout <= 1. It stays set until reset; flush does not clear it.
  - Counter saturates at 15; no wrap.
- Back-to-back stalls: a bubble is inserted each cycle; ifid_hold stays asserted.
- Reset mid-stall: counter cleared; stall_timeout cleared.

Optional Feature:
ID_EX_PERF_CNT_EN
- Defined: adds outputs bubble_cnt (32) and instr_cnt (32).
  - bubble_cnt increments on each edge where a bubble is loaded (stall or flush).
  - instr_cnt increments on each load with id_valid=1.
  - Both wrap modulo 2^32 and are reset to 0 by rst_n.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with all inputs random for 3 cycles -> all ex_* = 0, ex_valid=0, stall_timeout=0. Deassert; next edge with id_valid=1, id_op=0x23 -> ex_op=0x23, ex_valid=1.
- Normal load: id_op=0, funct=0x20, rs=3, rt=4, rd=5, rs_data=0x11, rt_data=0x22, alu_a_ex_eq=1, alu_a_mem_eq=1, alu_b_mem_eq=1 -> next cycle ex_rd=5, ex_fwd_a=01, ex_fwd_b=10, ex_rs_data=0x11.
- Load-use stall: stall=1 for one cycle with id_op=0x23 -> ifid_hold=1 the same cycle; next cycle ex_valid=0, ex_op=0, ex_rd=0, ex_fwd_a=00. Following cycle (stall=0) -> ex_op=0x23, ex_valid=1.
- Flush vs stall: flush=1, stall=1 together -> ifid_hold=0, bubble loaded, stall_run not incremented.
- Watchdog: MAX_STALL=4, stall=1 for 3 cycles -> stall_timeout=0. Stall for 4 cycles -> stall_timeout=1 after the 4th edge. Drop stall and pulse flush -> stall_timeout remains 1 until rst_n=0.
- Perf counters (macro defined): 5 valid loads, 2 stall bubbles, 1 flush -> instr_cnt=5, bubble_cnt=3. Preset bubble_cnt=0xFFFFFFFF, one bubble -> 0.
